register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_file_scoreboard.sv | 61 ++++++
 rtl/register_file.sv | 91 +++++++++
 tb/tb_register_file.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared processor definitions: default register-file geometry, the
// register-index type used by decode and writeback, and the rule that
// decides whether an index may be written or marked pending.
package register_file_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] regIdx_t;

  // An index is usable when it names a real register. When register 0 is
  // hardwired, index 0 is treated like an unused slot.
  function automatic logic idxWritable(input int idx, input int depth, input logic zeroReg);
    return (idx < depth) && !(zeroReg && (idx == 0));
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-bit scoreboard: one bit per register marks an outstanding producer.
// Issue sets a bit, writeback clears it, flush clears everything.
// Also keeps a registered popcount of the pending vector.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_addr_i,
  input  logic             flush_i,
  output logic [DEPTH-1:0] pending_o,
  output logic [CW-1:0]    pend_count_o
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wrOk, issOk;

  assign wrOk  = wr_en_i  && idxWritable(32'(wr_addr_i), DEPTH, ZERO_REG != 0);
  assign issOk = iss_en_i && idxWritable(32'(iss_addr_i), DEPTH, ZERO_REG != 0);

  // Next pending vector: writeback clears first so a same-edge issue to the
  // same register leaves it set; flush overrides both.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (wrOk)  pending_d[wr_addr_i]  = 1'b0;
      if (issOk) pending_d[iss_addr_i] = 1'b1;
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{(CW-1){1'b0}}, pending_d[i]};
    end
  end

  // Pending bits and their count update together so the count always
  // matches the vector after every edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_o    = pending_q;
  assign pend_count_o = count_q;

endmodule

// File: rtl/register_file.sv
// Register file with two combinational read ports, one write port with
// optional same-cycle forwarding, and a pending-bit scoreboard for issue
// tracking. Register 0 may be hardwired to zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_pend_a,
  output logic             rd_pend_b,
  output logic [CW-1:0]    pend_count
);

  logic [WIDTH-1:0] regArray_q [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             wrOk, issHitsWr;
  logic [AW-1:0]    rdAddr [2];
  logic [WIDTH-1:0] rdData [2];
  logic             rdPend [2];

  assign wrOk      = wr_en && idxWritable(32'(wr_addr), DEPTH, ZERO_REG != 0);
  assign issHitsWr = iss_en && !flush && (iss_addr == wr_addr);

  reg_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .flush_i     (flush),
    .pending_o   (pending),
    .pend_count_o(pend_count)
  );

  // Data array: writes land on the edge; a discarded index never changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regArray_q[i] <= '0;
    end else if (wrOk) begin
      regArray_q[wr_addr] <= wr_data;
    end
  end

  assign rdAddr[0] = rd_addr_a;
  assign rdAddr[1] = rd_addr_b;

  // Read ports: unusable indices read as zero and not pending; a matching
  // writeback is forwarded and shown as resolved unless a new producer
  // issues to the same register in the same cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = '0;
      rdPend[p] = 1'b0;
      if (idxWritable(32'(rdAddr[p]), DEPTH, ZERO_REG != 0)) begin
        rdData[p] = regArray_q[rdAddr[p]];
        rdPend[p] = pending[rdAddr[p]];
        if ((BYPASS != 0) && wrOk && (wr_addr == rdAddr[p])) begin
          rdData[p] = wr_data;
          rdPend[p] = issHitsWr;
        end
      end
    end
  end

  assign rd_data_a = rdData[0];
  assign rd_data_b = rdData[1];
  assign rd_pend_a = rdPend[0];
  assign rd_pend_b = rdPend[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. Stimulus is driven just after each rising
// edge and queues the values expected at the following falling edge; a
// monitor drains the queue on every falling edge and compares.
module tb_register_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 24;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam int F_DATA_A = 0;
  localparam int F_DATA_B = 1;
  localparam int F_PEND_A = 2;
  localparam int F_PEND_B = 3;
  localparam int F_COUNT  = 4;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] value;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_pend_a;
  logic             rd_pend_b;
  logic [CW-1:0]    pend_count;

  exp_t        expQ [$];
  exp_t        monE;
  logic [31:0] monActual;
  int          numChecks = 0;
  int          numFails  = 0;

  register_file #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_pend_a (rd_pend_a),
    .rd_pend_b (rd_pend_b),
    .pend_count(pend_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit in case the run stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every queued expectation is due at the next falling edge.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monE = expQ.pop_front();
      case (monE.field)
        F_DATA_A: monActual = rd_data_a;
        F_DATA_B: monActual = rd_data_b;
        F_PEND_A: monActual = {31'b0, rd_pend_a};
        F_PEND_B: monActual = {31'b0, rd_pend_b};
        default:  monActual = {{(32-CW){1'b0}}, pend_count};
      endcase
      numChecks++;
      if (monActual !== monE.value) begin
        numFails++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", monE.name, monActual, monE.value);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                               input logic ie, input logic [AW-1:0] ia, input logic fl,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    @(posedge clk);
    #1;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    iss_en    = ie;
    iss_addr  = ia;
    flush     = fl;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, ra, rb);
  endtask

  task automatic checkOutput(input string name, input int field, input logic [31:0] value);
    exp_t e;
    e.name  = name;
    e.field = field;
    e.value = value;
    expQ.push_back(e);
  endtask

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_en    = 1'b0;
    iss_addr  = '0;
    flush     = 1'b0;
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd0;
    checkOutput("reset_data_a", F_DATA_A, 32'h0);
    checkOutput("reset_count", F_COUNT, 32'd0);
    #12;
    reset = 1'b1;

    // Write with forwarding, then the stored value after the edge.
    applyStimulus(1'b1, 5'd3, 32'h2, 1'b0, '0, 1'b0, 5'd3, 5'd0);
    checkOutput("bypass_data_a", F_DATA_A, 32'h2);
    checkOutput("zero_reg_b", F_DATA_B, 32'h0);
    idle(5'd3, 5'd3);
    checkOutput("stored_data_a", F_DATA_A, 32'h2);
    checkOutput("same_addr_b", F_DATA_B, 32'h2);
    checkOutput("stored_pend_a", F_PEND_A, 32'd0);

    // Scoreboard: issue r7 then r9, writeback r7.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
    checkOutput("pre_issue_pend_b", F_PEND_B, 32'd0);
    checkOutput("pre_issue_count", F_COUNT, 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd7);
    checkOutput("r7_pend_b", F_PEND_B, 32'd1);
    checkOutput("count_one", F_COUNT, 32'd1);
    idle(5'd9, 5'd7);
    checkOutput("count_two", F_COUNT, 32'd2);
    checkOutput("r9_pend_a", F_PEND_A, 32'd1);
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, '0, 1'b0, 5'd0, 5'd7);
    checkOutput("wb_bypass_pend_b", F_PEND_B, 32'd0);
    checkOutput("wb_bypass_data_b", F_DATA_B, 32'h77);
    idle(5'd0, 5'd7);
    checkOutput("after_wb_count", F_COUNT, 32'd1);
    checkOutput("after_wb_pend_b", F_PEND_B, 32'd0);

    // Collision: r4 already pending, then issue and writeback together.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
    idle(5'd4, 5'd0);
    checkOutput("r4_issued_count", F_COUNT, 32'd2);
    applyStimulus(1'b1, 5'd4, 32'hA5A50004, 1'b1, 5'd4, 1'b0, 5'd4, 5'd0);
    checkOutput("collide_bypass_data", F_DATA_A, 32'hA5A50004);
    checkOutput("collide_bypass_pend", F_PEND_A, 32'd1);
    idle(5'd4, 5'd0);
    checkOutput("collide_data", F_DATA_A, 32'hA5A50004);
    checkOutput("collide_pend", F_PEND_A, 32'd1);
    checkOutput("collide_count", F_COUNT, 32'd2);

    // Register 0: write and issue are both discarded.
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("r0_bypass_data", F_DATA_A, 32'h0);
    checkOutput("r0_bypass_pend", F_PEND_A, 32'd0);
    idle(5'd0, 5'd0);
    checkOutput("r0_data", F_DATA_A, 32'h0);
    checkOutput("r0_pend", F_PEND_B, 32'd0);
    checkOutput("r0_count", F_COUNT, 32'd2);

    // Indices beyond the array are ignored.
    applyStimulus(1'b1, 5'd25, 32'hFFFF, 1'b1, 5'd26, 1'b0, 5'd25, 5'd0);
    checkOutput("oob_bypass_data", F_DATA_A, 32'h0);
    idle(5'd25, 5'd26);
    checkOutput("oob_data", F_DATA_A, 32'h0);
    checkOutput("oob_pend", F_PEND_B, 32'd0);
    checkOutput("oob_count", F_COUNT, 32'd2);

    // Flush: issue r1..r3, then flush alongside an issue of r6 and a write.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
    checkOutput("flush_pre_count3", F_COUNT, 32'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd6, 1'b1, 5'd3, 5'd6);
    checkOutput("flush_pre_count5", F_COUNT, 32'd5);
    checkOutput("flush_r3_pend", F_PEND_A, 32'd1);
    idle(5'd8, 5'd6);
    checkOutput("flush_count", F_COUNT, 32'd0);
    checkOutput("flush_r6_pend", F_PEND_B, 32'd0);
    checkOutput("flush_write_kept", F_DATA_A, 32'h88);

    // Reset mid-cycle: r5 holds a value, then reset drops between edges.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd10, 1'b0, 5'd5, 5'd0);
    checkOutput("r5_bypass", F_DATA_A, 32'hDEADBEEF);
    idle(5'd5, 5'd3);
    checkOutput("r5_stored", F_DATA_A, 32'hDEADBEEF);
    checkOutput("r10_count", F_COUNT, 32'd1);
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd11, 1'b0, 5'd5, 5'd3);
    reset = 1'b0;
    checkOutput("midreset_r5", F_DATA_A, 32'h0);
    checkOutput("midreset_r3", F_DATA_B, 32'h0);
    checkOutput("midreset_count", F_COUNT, 32'd0);
    idle(5'd6, 5'd11);
    reset = 1'b1;
    checkOutput("reset_drop_write", F_DATA_A, 32'h0);
    checkOutput("reset_drop_issue", F_PEND_B, 32'd0);
    checkOutput("reset_drop_count", F_COUNT, 32'd0);
    applyStimulus(1'b1, 5'd6, 32'h600D, 1'b1, 5'd12, 1'b0, 5'd0, 5'd0);
    idle(5'd6, 5'd12);
    checkOutput("post_reset_data", F_DATA_A, 32'h600D);
    checkOutput("post_reset_pend", F_PEND_B, 32'd1);
    checkOutput("post_reset_count", F_COUNT, 32'd1);

    // Let the monitor drain the last expectations before summarising.
    @(negedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
